// File: rtl/sprite_scheduler_if.sv
// sprite_scheduler_if
//   Bundles the sprite table configuration bus and the per-slot engine
//   control outputs of sprite_scheduler.
//   master : drives cfg_* (CPU/config side), observes slot_*
//   slave  : the scheduler; samples cfg_*, drives slot_*
//   cfg_we/cfg_addr/cfg_en/cfg_x/cfg_y : table write port
//   slot_start : per-engine one-cycle start pulse
//   slot_sprx  : per-engine x position, slot k at [k*CORDW +: CORDW]
//   slot_id    : table index owning each slot, slot k at [k*IDW +: IDW]
//   slot_busy  : slot occupied
interface sprite_scheduler_if #(
  parameter int CORDW   = 16,
  parameter int ENTRIES = 8,
  parameter int SLOTS   = 4,
  parameter int IDW     = $clog2(ENTRIES)
);
  logic                    cfg_we;
  logic [IDW-1:0]          cfg_addr;
  logic                    cfg_en;
  logic signed [CORDW-1:0] cfg_x;
  logic signed [CORDW-1:0] cfg_y;

  logic [SLOTS-1:0]        slot_start;
  logic [SLOTS*CORDW-1:0]  slot_sprx;
  logic [SLOTS*IDW-1:0]    slot_id;
  logic [SLOTS-1:0]        slot_busy;

  modport master (
    output cfg_we, cfg_addr, cfg_en, cfg_x, cfg_y,
    input  slot_start, slot_sprx, slot_id, slot_busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_en, cfg_x, cfg_y,
    output slot_start, slot_sprx, slot_id, slot_busy
  );
endinterface

// File: rtl/sprite_scheduler.sv
// sprite_scheduler
//   Line-based allocator sharing SLOTS sprite engines among an ENTRIES-deep
//   position table. On each line pulse the table is scanned one entry per
//   cycle; each sprite whose top row equals the current line takes the
//   lowest-numbered free engine, which is then held for HEIGHT lines.
//   clk, rst  : pixel clock, synchronous active-high reset
//   line      : start-of-line pulse, sy valid in the same cycle
//   frame     : start-of-frame pulse, frees all engines and clears ovf
//   sy        : current line
//   bus       : table write port and per-slot engine controls (slave side)
//   scan_done : one-cycle pulse when a scan completes
//   ovf       : sticky, a sprite was dropped or a scan was aborted
//
//   state | meaning
//   IDLE  | waiting for line
//   SCAN  | examining table entry idx this cycle
//   DONE  | scan finished, scan_done registered for next cycle
module sprite_scheduler #(
  parameter int CORDW   = 16,
  parameter int ENTRIES = 8,
  parameter int SLOTS   = 4,
  parameter int HEIGHT  = 8,
  parameter int IDW     = $clog2(ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line,
  input  logic                    frame,
  input  logic signed [CORDW-1:0] sy,
  sprite_scheduler_if.slave       bus,
  output logic                    scan_done,
  output logic                    ovf
);
  localparam int CW = $clog2(HEIGHT + 1);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]          idx;
  logic signed [CORDW-1:0] sy_q;
  logic [ENTRIES-1:0]      tbl_en;
  logic signed [CORDW-1:0] tbl_x [ENTRIES];
  logic signed [CORDW-1:0] tbl_y [ENTRIES];
  logic [CW-1:0]           cnt [SLOTS];

  logic [SLOTS-1:0]        start_q;
  logic [SLOTS*CORDW-1:0]  sprx_q;
  logic [SLOTS*IDW-1:0]    id_q;
  logic [SLOTS-1:0]        busy;

  logic                    examine, abort, done_pulse, hit, free_any;
  logic [SW-1:0]           free_k;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A line pulse always (re)starts a scan; an entry due in that cycle is
  // not examined since the scan it belonged to is being abandoned.
  always_comb begin
    state_nxt  = state;
    examine    = 1'b0;
    abort      = 1'b0;
    done_pulse = 1'b0;
    if (line) begin
      state_nxt = SCAN;
      abort     = (state != IDLE);
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        SCAN: begin
          examine = 1'b1;
          if (idx == IDW'(ENTRIES - 1)) state_nxt = DONE;
        end
        DONE: begin
          done_pulse = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < SLOTS; k++) busy[k] = (cnt[k] != '0);
  end

  // Lowest free slot; a slot allocated last cycle already has cnt = HEIGHT
  // so it cannot be handed out twice in one scan.
  always_comb begin
    hit      = examine && tbl_en[idx] && (tbl_y[idx] == sy_q);
    free_any = 1'b0;
    free_k   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (!busy[k]) begin
        free_any = 1'b1;
        free_k   = SW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      sy_q      <= '0;
      tbl_en    <= '0;
      start_q   <= '0;
      sprx_q    <= '0;
      id_q      <= '0;
      scan_done <= 1'b0;
      ovf       <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_x[i] <= '0;
        tbl_y[i] <= '0;
      end
      for (int k = 0; k < SLOTS; k++) cnt[k] <= '0;
    end else begin
      start_q   <= '0;
      scan_done <= done_pulse;

      if (bus.cfg_we) begin
        tbl_en[bus.cfg_addr] <= bus.cfg_en;
        tbl_x[bus.cfg_addr]  <= bus.cfg_x;
        tbl_y[bus.cfg_addr]  <= bus.cfg_y;
      end

      // frame clears before the line decrement; decrementing 0 is a no-op.
      for (int k = 0; k < SLOTS; k++) begin
        if (frame)                    cnt[k] <= '0;
        else if (line && busy[k])     cnt[k] <= cnt[k] - 1'b1;
      end

      if (line) begin
        sy_q <= sy;
        idx  <= '0;
      end else if (examine) begin
        idx  <= idx + 1'b1;
      end

      // Clear first so a set in the same cycle wins.
      if (frame) ovf <= 1'b0;
      if (abort) ovf <= 1'b1;

      if (hit) begin
        if (free_any) begin
          cnt[free_k]                    <= CW'(HEIGHT);
          start_q[free_k]                <= 1'b1;
          sprx_q[free_k*CORDW +: CORDW]  <= tbl_x[idx];
          id_q[free_k*IDW +: IDW]        <= idx;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.slot_start = start_q;
  assign bus.slot_sprx  = sprx_q;
  assign bus.slot_id    = id_q;
  assign bus.slot_busy  = busy;
endmodule
